// File: rtl/reg_bank_wr_arbiter_if.sv
// Write-path bundle between requesters A/B, the arbiter and the register bank.
// prot_err exists only when REG_ARB_PROT_EN is defined.
interface reg_bank_wr_arbiter_if #(
    parameter int NREGS = 4,
    parameter int AW    = 2
);
    logic             a_req;
    logic [AW-1:0]    a_addr;
    logic [1:0]       a_len;
    logic [15:0]      a_data;
    logic             a_gnt;
    logic             a_ack;
    logic             b_req;
    logic [AW-1:0]    b_addr;
    logic [1:0]       b_len;
    logic [15:0]      b_data;
    logic             b_gnt;
    logic             b_ack;
    logic [NREGS-1:0] reg_en;
    logic [15:0]      reg_wdata;
    logic             busy;
`ifdef REG_ARB_PROT_EN
    logic             prot_err;
`endif

    modport master (
        output a_req, a_addr, a_len, a_data, b_req, b_addr, b_len, b_data,
        input  a_gnt, a_ack, b_gnt, b_ack, reg_en, reg_wdata, busy
`ifdef REG_ARB_PROT_EN
        , input prot_err
`endif
    );

    modport slave (
        input  a_req, a_addr, a_len, a_data, b_req, b_addr, b_len, b_data,
        output a_gnt, a_ack, b_gnt, b_ack, reg_en, reg_wdata, busy
`ifdef REG_ARB_PROT_EN
        , output prot_err
`endif
    );
endinterface

// File: rtl/reg_bank_wr_arbiter.sv
// Round-robin burst write arbiter for a bank of NREGS 16-bit registers.
// Define REG_ARB_PROT_EN to write-protect register 0 against requester B.
module reg_bank_wr_arbiter #(
    parameter int NREGS = 4,
    parameter int AW    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_bank_wr_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BURST_A = 2'd1;
    localparam logic [1:0] BURST_B = 2'd2;

    logic [1:0]    state, state_nxt;
    logic          prio, prio_nxt;
    logic [AW-1:0] cur_addr, addr_nxt;
    logic [1:0]    beats_left, beats_nxt;
    logic          own_a, own_b, beat, wr;
    logic [15:0]   data_sel;

    // All outputs decode from state, so an async reset clears them without a clock edge.
    assign own_a    = (state == BURST_A);
    assign own_b    = (state == BURST_B);
    assign beat     = (own_a && bus.a_req) || (own_b && bus.b_req);
    assign data_sel = own_a ? bus.a_data : bus.b_data;

`ifdef REG_ARB_PROT_EN
    logic blocked;
    assign blocked = own_b && bus.b_req && (cur_addr == '0);
    assign wr      = beat && !blocked;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bus.prot_err <= 1'b0;
        else      bus.prot_err <= blocked;
    end
`else
    assign wr = beat;
`endif

    assign bus.a_gnt     = own_a;
    assign bus.b_gnt     = own_b;
    assign bus.busy      = own_a || own_b;
    assign bus.a_ack     = own_a && bus.a_req;
    assign bus.b_ack     = own_b && bus.b_req;
    assign bus.reg_wdata = beat ? data_sel : 16'h0;
    assign bus.reg_en    = wr ? (NREGS'(1) << cur_addr) : '0;

    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        addr_nxt  = cur_addr;
        beats_nxt = beats_left;
        case (state)
            IDLE: begin
                if (bus.a_req && (!bus.b_req || !prio)) begin
                    state_nxt = BURST_A;
                    addr_nxt  = bus.a_addr;
                    beats_nxt = bus.a_len;
                end else if (bus.b_req) begin
                    state_nxt = BURST_B;
                    addr_nxt  = bus.b_addr;
                    beats_nxt = bus.b_len;
                end
            end
            BURST_A, BURST_B: begin
                if (beat) begin
                    addr_nxt  = cur_addr + AW'(1);
                    beats_nxt = beats_left - 2'd1;
                end
                // Last beat or abort: hand preference to the requester that just lost.
                if (!beat || beats_left == 2'd0) begin
                    state_nxt = IDLE;
                    prio_nxt  = own_a;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            prio       <= 1'b0;
            cur_addr   <= '0;
            beats_left <= 2'd0;
        end else begin
            state      <= state_nxt;
            prio       <= prio_nxt;
            cur_addr   <= addr_nxt;
            beats_left <= beats_nxt;
        end
    end
endmodule
